// File: rtl/wb_sdram_ctrl_fsm_p.sv
// Parametrised SDRAM command sequencer for the Wishbone SDRAM controller.
// Covers power-up init, auto-refresh and read/write bursts. Every SDRAM
// timing is counted by one shared wait counter instead of chains of NOP
// states. OPEN_ROW=1 keeps the last accessed row open so that later page
// hits skip the ACTIVATE.
// All bus outputs are registered: the value for the state being entered is
// computed from the next state and loaded on the same edge as the state, so
// the command on the bus always matches the current state.
module wb_sdram_ctrl_fsm_p #(
    parameter int               BA_W      = 2,
    parameter int               ROW_W     = 13,
    parameter int               COL_W     = 9,
    parameter int               T_RP      = 2,
    parameter int               T_RCD     = 2,
    parameter int               T_RFC     = 7,
    parameter int               T_MRD     = 2,
    parameter int               INIT_REFS = 2,
    parameter logic [ROW_W-1:0] MODE_REG  = 'h0032,
    parameter int               OPEN_ROW  = 0
) (
    input  logic             sdram_clk,
    input  logic             wb_rst,
    input  logic             init_start,
    input  logic             ref_req,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic             end_of_burst,
    input  logic             abort,
    output logic             req_ready,
    output logic [2:0]       cmd,
    output logic             cs_n,
    output logic [BA_W-1:0]  ba,
    output logic [ROW_W-1:0] a,
    output logic             rd_ack,
    output logic             wr_ack,
    output logic             ref_ack,
    output logic             init_done
);

    // Widest timing decides the wait counter width; it only ever holds T_x-1.
    localparam int T_MAX01 = (T_RP  > T_RCD) ? T_RP  : T_RCD;
    localparam int T_MAX23 = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
    localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [3:0] S_RST_WAIT = 4'd0;
    localparam logic [3:0] S_PRE_ALL  = 4'd1;
    localparam logic [3:0] S_INIT_REF = 4'd2;
    localparam logic [3:0] S_LMR      = 4'd3;
    localparam logic [3:0] S_IDLE     = 4'd4;
    localparam logic [3:0] S_REF_PRE  = 4'd5;
    localparam logic [3:0] S_REF      = 4'd6;
    localparam logic [3:0] S_ACT      = 4'd7;
    localparam logic [3:0] S_PRE_MISS = 4'd8;
    localparam logic [3:0] S_RW       = 4'd9;
    localparam logic [3:0] S_PRE_END  = 4'd10;
    localparam logic [3:0] S_WAIT     = 4'd11;

    localparam logic [2:0] C_NOP   = 3'b111;
    localparam logic [2:0] C_ACT   = 3'b011;
    localparam logic [2:0] C_READ  = 3'b101;
    localparam logic [2:0] C_WRITE = 3'b100;
    localparam logic [2:0] C_PRE   = 3'b010;
    localparam logic [2:0] C_AREF  = 3'b001;
    localparam logic [2:0] C_LMR   = 3'b000;

    logic [3:0]       state, state_n, ret, ret_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       irefs, irefs_n;
    logic             row_open, row_open_n;
    logic [BA_W-1:0]  open_ba, open_ba_n;
    logic [ROW_W-1:0] open_row, open_row_n;
    logic             l_we, l_we_n;
    logic [BA_W-1:0]  l_ba, l_ba_n;
    logic [ROW_W-1:0] l_row, l_row_n;
    logic [COL_W-1:0] l_col, l_col_n;

    logic             go;
    int               go_t;
    logic [3:0]       go_tgt;

    logic [2:0]       cmd_n;
    logic             cs_n_n, rd_n, wr_n, rf_n, init_done_n;
    logic [BA_W-1:0]  ba_n;
    logic [ROW_W-1:0] a_n;

    logic             row_hit;

    assign row_hit   = (OPEN_ROW != 0) && row_open && (req_ba == open_ba) && (req_row == open_row);
    assign req_ready = (state == S_IDLE) && !ref_req;

    // Next-state logic; command states request a timed wait through go/go_t/go_tgt.
    always_comb begin
        state_n    = state;
        ret_n      = ret;
        cnt_n      = cnt;
        irefs_n    = irefs;
        row_open_n = row_open;
        open_ba_n  = open_ba;
        open_row_n = open_row;
        l_we_n     = l_we;
        l_ba_n     = l_ba;
        l_row_n    = l_row;
        l_col_n    = l_col;
        go         = 1'b0;
        go_t       = 1;
        go_tgt     = S_IDLE;
        case (state)
            S_RST_WAIT: begin
                irefs_n    = '0;
                row_open_n = 1'b0;
                if (init_start) state_n = S_PRE_ALL;
            end
            S_PRE_ALL: begin
                go = 1'b1; go_t = T_RP; go_tgt = S_INIT_REF;
            end
            S_INIT_REF: begin
                irefs_n = irefs + 4'd1;
                go      = 1'b1;
                go_t    = T_RFC;
                go_tgt  = (irefs == 4'(INIT_REFS - 1)) ? S_LMR : S_INIT_REF;
            end
            S_LMR: begin
                go = 1'b1; go_t = T_MRD; go_tgt = S_IDLE;
            end
            S_IDLE: begin
                if (ref_req) begin
                    state_n = row_open ? S_REF_PRE : S_REF;
                end else if (req_valid) begin
                    l_we_n  = req_we;
                    l_ba_n  = req_ba;
                    l_row_n = req_row;
                    l_col_n = req_col;
                    if (row_hit)
                        state_n = S_RW;
                    else if ((OPEN_ROW != 0) && row_open)
                        state_n = S_PRE_MISS;
                    else
                        state_n = S_ACT;
                end
            end
            S_REF_PRE: begin
                row_open_n = 1'b0;
                go = 1'b1; go_t = T_RP; go_tgt = S_REF;
            end
            S_REF: begin
                go = 1'b1; go_t = T_RFC; go_tgt = S_IDLE;
            end
            S_ACT: begin
                go = 1'b1; go_t = T_RCD; go_tgt = S_RW;
            end
            S_PRE_MISS: begin
                row_open_n = 1'b0;
                go = 1'b1; go_t = T_RP; go_tgt = S_ACT;
            end
            S_RW: begin
                if (abort) begin
                    row_open_n = 1'b0;
                    state_n    = S_PRE_END;
                end else if (end_of_burst) begin
                    if (OPEN_ROW != 0) begin
                        state_n    = S_IDLE;
                        row_open_n = 1'b1;
                        open_ba_n  = l_ba;
                        open_row_n = l_row;
                    end else begin
                        state_n = S_PRE_END;
                    end
                end
            end
            S_PRE_END: begin
                row_open_n = 1'b0;
                go = 1'b1; go_t = T_RP; go_tgt = S_IDLE;
            end
            S_WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt <= CNT_W'(1)) state_n = ret;
            end
            default: state_n = S_RST_WAIT;
        endcase
        // A timing of one cycle needs no WAIT: the next command follows directly.
        if (go) begin
            if (go_t > 1) begin
                state_n = S_WAIT;
                ret_n   = go_tgt;
                cnt_n   = CNT_W'(go_t - 1);
            end else begin
                state_n = go_tgt;
            end
        end
    end

    // Bus values for the state being entered (registered below with the state).
    always_comb begin
        cmd_n  = C_NOP;
        cs_n_n = 1'b0;
        ba_n   = '0;
        a_n    = '0;
        rd_n   = 1'b0;
        wr_n   = 1'b0;
        rf_n   = 1'b0;
        case (state_n)
            S_RST_WAIT, S_IDLE: cs_n_n = 1'b1;
            S_PRE_ALL, S_REF_PRE, S_PRE_END: begin
                cmd_n  = C_PRE;
                a_n[10] = 1'b1;
            end
            S_INIT_REF: cmd_n = C_AREF;
            S_REF: begin
                cmd_n = C_AREF;
                rf_n  = 1'b1;
            end
            S_LMR: begin
                cmd_n = C_LMR;
                a_n   = MODE_REG;
            end
            S_ACT: begin
                cmd_n = C_ACT;
                ba_n  = l_ba_n;
                a_n   = l_row_n;
            end
            S_PRE_MISS: begin
                cmd_n = C_PRE;
                ba_n  = open_ba;
            end
            S_RW: begin
                cmd_n = l_we_n ? C_WRITE : C_READ;
                ba_n  = l_ba_n;
                a_n   = ROW_W'(l_col_n);
                rd_n  = !l_we_n;
                wr_n  = l_we_n;
            end
            default: ;
        endcase
        init_done_n = (state_n == S_IDLE) || (init_done && (state_n != S_RST_WAIT));
    end

    // State, latched request, open-row tracking and registered bus outputs.
    always_ff @(posedge sdram_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state     <= S_RST_WAIT;
            ret       <= S_RST_WAIT;
            cnt       <= '0;
            irefs     <= '0;
            row_open  <= 1'b0;
            open_ba   <= '0;
            open_row  <= '0;
            l_we      <= 1'b0;
            l_ba      <= '0;
            l_row     <= '0;
            l_col     <= '0;
            cmd       <= C_NOP;
            cs_n      <= 1'b1;
            ba        <= '0;
            a         <= '0;
            rd_ack    <= 1'b0;
            wr_ack    <= 1'b0;
            ref_ack   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            ret       <= ret_n;
            cnt       <= cnt_n;
            irefs     <= irefs_n;
            row_open  <= row_open_n;
            open_ba   <= open_ba_n;
            open_row  <= open_row_n;
            l_we      <= l_we_n;
            l_ba      <= l_ba_n;
            l_row     <= l_row_n;
            l_col     <= l_col_n;
            cmd       <= cmd_n;
            cs_n      <= cs_n_n;
            ba        <= ba_n;
            a         <= a_n;
            rd_ack    <= rd_n;
            wr_ack    <= wr_n;
            ref_ack   <= rf_n;
            init_done <= init_done_n;
        end
    end

endmodule
